unary_window_decoder: RTL and testbench
=======================================

Name: unary_window_decoder

Overview:
- Decoder end of the unary bitstream path. It recovers a WIDTH-bit binary value from a unary (rate-coded) bitstream, such as one produced by a Sobol RNG feeding a comparator.
- It counts the 1s over a window of 2^winLog enabled bits, then scales the count to full WIDTH resolution.
- The result is presented on a valid/ready output. Sits at the output of uGEMM/uMUL rate-coded datapaths, ahead of binary writeback.

Parameters:
- WIDTH, 8, output binary width; maximum window is 2^WIDTH bits.
- LOGWIDTH, 3, log2(WIDTH); winLog port is LOGWIDTH+1 bits wide.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin a new accumulation window.
- winLog  input  LOGWIDTH+1  log2 of window length; sampled only on an accepted start.
- enable  input  1  inBit is valid this cycle (same meaning as the uMUL enable).
- inBit  input  1  unary bitstream bit.
- busy  output  1  high in ACCUM.
- outValid  output  1  result available.
- outReady  input  1  consumer accepts the result.
- outData  output  WIDTH  decoded binary value.

Behaviour:
- One clock; reset is synchronous and active-high.
  - rst high at a clk edge forces: state=IDLE, onesCnt=0, bitCnt=0, winReg=0, busy=0, outValid=0, outData=0.
  - rst dominates all other inputs.
  - Reset mid-window discards the partial count; no result is produced.
- Internal registers:
  - onesCnt, WIDTH+1 bits.
  - bitCnt, WIDTH+1 bits.
  - winReg, LOGWIDTH+1 bits, clamped: winLog>WIDTH is stored as WIDTH.
- IDLE:
  - start=1: load winReg, clear onesCnt and bitCnt, go to ACCUM.
  - enable/inBit are ignored in the start cycle and in IDLE.
- ACCUM:
  - On each cycle with enable=1: onesCnt += inBit; bitCnt += 1.
  - enable=0: hold both counters.
  - When enable=1 and bitCnt == 2^winReg - 1, the current bit is the last of the window:
    - next state is HOLD;
    - outData is registered as scale(onesCnt + inBit);
    - outValid=1 on the following cycle.
  - Latency: one cycle from the last enabled bit to outValid.
  - start is ignored in ACCUM.
- scale(c), with c in [0, 2^winReg]:
  - s = c << (WIDTH - winReg), computed in WIDTH+1 bits.
  - If s[WIDTH]=1 (every bit was 1), outData = 2^WIDTH-1 (saturate); otherwise outData = s[WIDTH-1:0].
- HOLD:
  - outValid=1 and outData stable until the handshake completes (outValid & outReady at a clk edge).
  - No bits are sampled in HOLD.
  - Handshake with start=0: go to IDLE, outValid=0; outData keeps its last value.
  - Handshake with start=1: go straight to ACCUM with the new winLog and cleared counters (zero-bubble back-to-back).
  - start without outReady: ignored.
- winReg=0: window of 1 bit. Result is 0 or 2^WIDTH-1.
- busy = (state==ACCUM).

Test Plan:
- rst, start winLog=8, 256 enabled bits all 1 -> outValid exactly 1 cycle after the 256th bit; outData=255 (saturated); busy low in HOLD.
- start winLog=8, bits alternating 1,0 for 256 bits -> outData=128; same stream of all 0s -> outData=0.
- start winLog=4, 16 bits with five 1s, enable deasserted for 3 random cycles mid-window -> outData=80. Gaps do not count: outValid only after the 16th enabled bit.
- Result ready with outReady=0 for 5 cycles -> outValid=1 and outData stable throughout. Then outReady=1 with start=1, winLog=2, next bits 1,1,0,1 -> IDLE skipped, second result 3<<6=192.
- winLog=9 (clamped to 8) with 100 ones in 256 bits -> outData=100. winLog=0 with inBit=1 -> 255; winLog=0 with inBit=0 -> 0.
- Assert rst after 37 bits of a winLog=8 window -> next cycle all outputs 0, state IDLE. Fresh start then yields a correct result with no residue from the aborted window.

Source files
------------

// File: rtl/unary_window_decoder_if.sv
// Handshake and bitstream signals between a unary-stream source/consumer and the window decoder.
interface unary_window_decoder_if #(
  parameter int WIDTH    = 8,
  parameter int LOGWIDTH = 3
);
  logic                start;
  logic [LOGWIDTH:0]   winLog;
  logic                enable;
  logic                inBit;
  logic                busy;
  logic                outValid;
  logic                outReady;
  logic [WIDTH-1:0]    outData;

  modport master (
    output start, winLog, enable, inBit, outReady,
    input  busy, outValid, outData
  );

  modport slave (
    input  start, winLog, enable, inBit, outReady,
    output busy, outValid, outData
  );
endinterface

// File: rtl/unary_window_decoder.sv
// Counts 1s over a window of 2^winLog enabled bits and rescales the count to WIDTH bits.
module unary_window_decoder #(
  parameter int WIDTH    = 8,
  parameter int LOGWIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  unary_window_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [LOGWIDTH:0] WMAX = (LOGWIDTH+1)'(WIDTH);
  localparam logic [WIDTH:0]    ONE  = (WIDTH+1)'(1);

  state_t            state_q, state_d;
  logic [WIDTH:0]    ones_q, ones_d;
  logic [WIDTH:0]    bits_q, bits_d;
  logic [LOGWIDTH:0] win_q, win_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;

  logic [LOGWIDTH:0] win_clamp;
  logic [WIDTH:0]    last_idx;
  logic [WIDTH:0]    count;
  logic [WIDTH:0]    scaled;

  always_comb begin
    win_clamp = (bus.winLog > WMAX) ? WMAX : bus.winLog;
    last_idx  = (ONE << win_q) - ONE;
    count     = ones_q + {{WIDTH{1'b0}}, bus.inBit};
    // A full window of 1s overflows into bit WIDTH and saturates.
    scaled    = count << (WMAX - win_q);
  end

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    bits_d  = bits_q;
    win_d   = win_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          win_d   = win_clamp;
          ones_d  = '0;
          bits_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.enable) begin
          ones_d = count;
          bits_d = bits_q + ONE;
          if (bits_q == last_idx) begin
            state_d = HOLD;
            valid_d = 1'b1;
            data_d  = scaled[WIDTH] ? '1 : scaled[WIDTH-1:0];
          end
        end
      end
      HOLD: begin
        if (bus.outReady) begin
          valid_d = 1'b0;
          if (bus.start) begin
            win_d   = win_clamp;
            ones_d  = '0;
            bits_d  = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ones_q  <= '0;
      bits_q  <= '0;
      win_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      bits_q  <= bits_d;
      win_q   <= win_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy     = (state_q == ACCUM);
  assign bus.outValid = valid_q;
  assign bus.outData  = data_q;
endmodule

// File: tb/tb_unary_window_decoder.sv
// Randomised bench for unary_window_decoder: per-cycle behavioural model plus literal result pins.
module tb_unary_window_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unary_window_decoder_if #(.WIDTH(8), .LOGWIDTH(3)) ifc ();

  unary_window_decoder #(.WIDTH(8), .LOGWIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int fails  = 0;
  bit armed  = 1'b0;

  // Behavioural model: window length in bits, bits seen, ones seen, presented result.
  int m_mode  = 0;  // 0 idle, 1 accumulating, 2 result pending
  int m_len   = 1;
  int m_seen  = 0;
  int m_ones  = 0;
  int m_data  = 0;
  bit m_valid = 1'b0;

  bit q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function void open_window(input int wl);
    int w;
    w = (wl > 8) ? 8 : wl;
    m_len  = 1 << w;
    m_seen = 0;
    m_ones = 0;
    m_mode = 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_valid = 1'b0; m_data = 0; m_seen = 0; m_ones = 0;
    end else begin
      case (m_mode)
        0: if (ifc.start) open_window(int'(ifc.winLog));
        1: if (ifc.enable) begin
             m_seen++;
             m_ones += int'(ifc.inBit);
             if (m_seen == m_len) begin
               m_data = (m_ones * 256) / m_len;
               if (m_data > 255) m_data = 255;
               m_valid = 1'b1;
               m_mode  = 2;
             end
           end
        default: if (ifc.outReady) begin
             m_valid = 1'b0;
             if (ifc.start) open_window(int'(ifc.winLog));
             else m_mode = 0;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy",     32'(ifc.busy),     32'(m_mode == 1));
      chk("outValid", 32'(ifc.outValid), 32'(m_valid));
      chk("outData",  32'(ifc.outData),  32'(m_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_win(input int w);
    ifc.start  = 1'b1;
    ifc.winLog = 4'(w);
    ifc.enable = 1'($urandom);
    ifc.inBit  = 1'($urandom);
    step();
    ifc.start  = 1'b0;
    ifc.enable = 1'b0;
  endtask

  task automatic send_bits(input int gap_pct);
    while (q.size() > 0) begin
      if ($urandom_range(99, 0) < gap_pct) begin
        ifc.enable = 1'b0;
        ifc.inBit  = 1'($urandom);
      end else begin
        ifc.enable = 1'b1;
        ifc.inBit  = q.pop_front();
      end
      step();
    end
    ifc.enable = 1'b0;
  endtask

  task automatic accept(input int delay, input bit st, input int w, input int exp);
    for (int i = 0; i < delay; i++) begin
      ifc.outReady = 1'b0;
      ifc.start    = 1'($urandom);
      ifc.enable   = 1'($urandom);
      ifc.inBit    = 1'($urandom);
      step();
      chk("hold_valid", 32'(ifc.outValid), 32'd1);
      chk("hold_data",  32'(ifc.outData),  32'(exp));
    end
    ifc.outReady = 1'b1;
    ifc.start    = st;
    ifc.winLog   = 4'(w);
    ifc.enable   = 1'b0;
    step();
    ifc.outReady = 1'b0;
    ifc.start    = 1'b0;
  endtask

  task automatic push_count(input int n, input int ones);
    int left;
    left = ones;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(n - i - 1, 0) < left) begin
        q.push_back(1'b1);
        left--;
      end else begin
        q.push_back(1'b0);
      end
    end
  endtask

  initial begin
    bit b2b;
    int nw;
    ifc.start = 1'b0; ifc.winLog = '0; ifc.enable = 1'b0;
    ifc.inBit = 1'b0; ifc.outReady = 1'b0;
    step();
    armed = 1'b1;
    chk("rst_busy",  32'(ifc.busy),     32'd0);
    chk("rst_valid", 32'(ifc.outValid), 32'd0);
    chk("rst_data",  32'(ifc.outData),  32'd0);
    rst = 1'b0;

    // All ones over 256 bits saturates; result one cycle after last bit.
    begin_win(8);
    for (int i = 0; i < 256; i++) q.push_back(1'b1);
    send_bits(0);
    chk("all1_valid", 32'(ifc.outValid), 32'd1);
    chk("all1_busy",  32'(ifc.busy),     32'd0);
    chk("all1_data",  32'(ifc.outData),  32'd255);
    accept(0, 1'b0, 0, 255);

    begin_win(8);
    for (int i = 0; i < 256; i++) q.push_back(1'((i + 1) % 2));
    send_bits(20);
    chk("alt_data", 32'(ifc.outData), 32'd128);
    accept(1, 1'b0, 0, 128);

    begin_win(8);
    for (int i = 0; i < 256; i++) q.push_back(1'b0);
    send_bits(10);
    chk("zero_data", 32'(ifc.outData), 32'd0);
    accept(0, 1'b0, 0, 0);

    // Five ones in 16, with three disabled cycles mid-window.
    begin_win(4);
    for (int i = 0; i < 16; i++) q.push_back(1'(i % 3 == 0 && i < 13));
    for (int i = 0; i < 8; i++) begin ifc.enable = 1'b1; ifc.inBit = q.pop_front(); step(); end
    for (int i = 0; i < 3; i++) begin ifc.enable = 1'b0; ifc.inBit = 1'b1; step(); end
    chk("gap_valid", 32'(ifc.outValid), 32'd0);
    send_bits(0);
    chk("gap_valid_end", 32'(ifc.outValid), 32'd1);
    chk("gap_data",      32'(ifc.outData),  32'd80);
    accept(5, 1'b1, 2, 80);
    chk("b2b_busy", 32'(ifc.busy), 32'd1);
    q.push_back(1'b1); q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1);
    send_bits(0);
    chk("b2b_data", 32'(ifc.outData), 32'd192);
    accept(0, 1'b0, 0, 192);

    // winLog above WIDTH clamps to a 256-bit window.
    begin_win(9);
    push_count(256, 100);
    send_bits(25);
    chk("clamp_data", 32'(ifc.outData), 32'd100);
    accept(2, 1'b0, 0, 100);

    begin_win(0);
    q.push_back(1'b1);
    send_bits(0);
    chk("w0_one", 32'(ifc.outData), 32'd255);
    accept(0, 1'b0, 0, 255);

    // Abort a window with reset; outData must also clear.
    begin_win(8);
    for (int i = 0; i < 37; i++) q.push_back(1'($urandom));
    send_bits(0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy",  32'(ifc.busy),     32'd0);
    chk("abort_valid", 32'(ifc.outValid), 32'd0);
    chk("abort_data",  32'(ifc.outData),  32'd0);
    begin_win(3);
    q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b0);
    q.push_back(1'b0); q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b0);
    send_bits(30);
    chk("fresh_data", 32'(ifc.outData), 32'd96);
    accept(0, 1'b0, 0, 96);

    begin_win(0);
    q.push_back(1'b0);
    send_bits(0);
    chk("w0_zero", 32'(ifc.outData), 32'd0);
    accept(0, 1'b0, 0, 0);

    // Randomised windows with random gaps, stalls and back-to-back restarts.
    b2b = 1'b0;
    nw  = 0;
    for (int k = 0; k < 30; k++) begin
      int w, len, dens;
      if (!b2b) begin
        nw = $urandom_range(15, 0);
        for (int i = 0; i < $urandom_range(2, 0); i++) begin
          ifc.enable = 1'($urandom); ifc.inBit = 1'($urandom); step();
        end
        begin_win(nw);
      end
      w    = (nw > 8) ? 8 : nw;
      len  = 1 << w;
      dens = $urandom_range(100, 0);
      for (int i = 0; i < len; i++) q.push_back(1'($urandom_range(99, 0) < dens));
      send_bits(30);
      chk("rnd_valid", 32'(ifc.outValid), 32'd1);
      b2b = 1'($urandom);
      nw  = $urandom_range(15, 0);
      accept($urandom_range(3, 0), b2b, nw, m_data);
    end

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
